// File: rtl/vx_fetch_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : vx_fetch_sched_if
//  Description : Fetch-request handshake bundle between the warp scheduler
//                (master) and the fetch stage (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface vx_fetch_sched_if #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int PC_BITS     = 31,
  parameter int UUID_WIDTH  = 16
);
  localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  logic                   sched_valid;
  logic                   sched_ready;
  logic [NW_WIDTH-1:0]    sched_wid;
  logic [PC_BITS-1:0]     sched_pc;
  logic [NUM_THREADS-1:0] sched_tmask;
  logic [UUID_WIDTH-1:0]  sched_uuid;

  modport master (
    output sched_valid, sched_wid, sched_pc, sched_tmask, sched_uuid,
    input  sched_ready
  );

  modport slave (
    input  sched_valid, sched_wid, sched_pc, sched_tmask, sched_uuid,
    output sched_ready
  );
endinterface
`default_nettype wire

// File: rtl/vx_fetch_sched.sv
`default_nettype none
// ============================================================================
//  Module      : vx_fetch_sched
//  Description : Per-core warp fetch scheduler. Tracks active/PC/tmask and
//                in-flight count per warp, picks one eligible warp per cycle
//                round-robin and presents a registered fetch request.
//  Revision    : 1.0 - initial release
// ============================================================================
module vx_fetch_sched #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_THREADS  = 4,
  parameter int PC_BITS      = 31,
  parameter int UUID_WIDTH   = 16,
  parameter int MAX_INFLIGHT = 2,
  localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,

  input  logic                   start_valid,
  input  logic [NW_WIDTH-1:0]    start_wid,
  input  logic [PC_BITS-1:0]     start_pc,
  input  logic [NUM_THREADS-1:0] start_tmask,

  input  logic                   stop_valid,
  input  logic [NW_WIDTH-1:0]    stop_wid,

  input  logic                   redir_valid,
  input  logic [NW_WIDTH-1:0]    redir_wid,
  input  logic [PC_BITS-1:0]     redir_pc,

  input  logic [NUM_WARPS-1:0]   ibuf_pop,

  vx_fetch_sched_if.master       sched_if,

  output logic [NUM_WARPS-1:0]   active_warps,
  output logic                   busy
);

  // Pending counter is wide enough for the largest legal MAX_INFLIGHT (15).
  localparam int              PEND_W   = 4;
  localparam logic [PEND_W-1:0] MAX_PEND = PEND_W'(MAX_INFLIGHT);

  // Per-warp architectural state
  logic [NUM_WARPS-1:0]   active_q, active_d;
  logic [PC_BITS-1:0]     pc_q      [NUM_WARPS];
  logic [PC_BITS-1:0]     pc_d      [NUM_WARPS];
  logic [NUM_THREADS-1:0] tmask_q   [NUM_WARPS];
  logic [NUM_THREADS-1:0] tmask_d   [NUM_WARPS];
  logic [PEND_W-1:0]      pending_q [NUM_WARPS];
  logic [PEND_W-1:0]      pending_d [NUM_WARPS];

  // Arbitration and uuid state
  logic [NW_WIDTH-1:0]    last_grant_q, last_grant_d;
  logic [UUID_WIDTH-1:0]  uuid_q, uuid_d;

  // Output slot
  logic                   out_valid_q, out_valid_d;
  logic [NW_WIDTH-1:0]    out_wid_q, out_wid_d;
  logic [PC_BITS-1:0]     out_pc_q, out_pc_d;
  logic [NUM_THREADS-1:0] out_tmask_q, out_tmask_d;
  logic [UUID_WIDTH-1:0]  out_uuid_q, out_uuid_d;
  logic                   busy_q, busy_d;

  // Combinational helpers
  logic [NUM_WARPS-1:0]   start_hit, stop_hit, redir_hit, eligible, grant_sel;
  logic                   load, grant_found, grant;
  logic [NW_WIDTH-1:0]    grant_wid, cand;
  logic                   any_pending;

  assign load  = ~out_valid_q | sched_if.sched_ready;
  assign grant = load & grant_found;

  // Decode control strobes per warp and derive eligibility
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      start_hit[w] = start_valid && (start_wid == NW_WIDTH'(w));
      stop_hit[w]  = stop_valid  && (stop_wid  == NW_WIDTH'(w));
      redir_hit[w] = redir_valid && (redir_wid == NW_WIDTH'(w));
      eligible[w]  = active_q[w] && (pending_q[w] < MAX_PEND) &&
                     !stop_hit[w] && !redir_hit[w];
    end
  end

  // Round-robin search starting just after the last granted warp
  always_comb begin
    grant_found = 1'b0;
    grant_wid   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      cand = last_grant_q + NW_WIDTH'(i);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_wid   = cand;
      end
    end
    for (int w = 0; w < NUM_WARPS; w++) begin
      grant_sel[w] = grant && (grant_wid == NW_WIDTH'(w));
    end
  end

  // Per-warp next state: start beats redirect beats increment
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      active_d[w]  = active_q[w];
      pc_d[w]      = pc_q[w];
      tmask_d[w]   = tmask_q[w];
      pending_d[w] = pending_q[w];

      if (grant_sel[w]) pc_d[w] = pc_q[w] + PC_BITS'(2);
      if (redir_hit[w]) pc_d[w] = redir_pc;
      if (stop_hit[w])  active_d[w] = 1'b0;
      if (start_hit[w]) begin
        if (start_tmask != '0) begin
          active_d[w] = 1'b1;
          pc_d[w]     = start_pc;
          tmask_d[w]  = start_tmask;
        end else begin
          active_d[w] = 1'b0;
        end
      end

      // A pop against an empty count is dropped (and flagged below)
      if (grant_sel[w] && !ibuf_pop[w]) begin
        pending_d[w] = pending_q[w] + PEND_W'(1);
      end else if (!grant_sel[w] && ibuf_pop[w] && (pending_q[w] != '0)) begin
        pending_d[w] = pending_q[w] - PEND_W'(1);
      end
    end
  end

  // Output slot, arbitration pointer, uuid and busy next state
  always_comb begin
    out_valid_d  = out_valid_q;
    out_wid_d    = out_wid_q;
    out_pc_d     = out_pc_q;
    out_tmask_d  = out_tmask_q;
    out_uuid_d   = out_uuid_q;
    last_grant_d = last_grant_q;
    uuid_d       = uuid_q;

    if (load) begin
      out_valid_d = grant_found;
    end
    if (grant) begin
      out_wid_d    = grant_wid;
      out_pc_d     = pc_q[grant_wid];
      out_tmask_d  = tmask_q[grant_wid];
      out_uuid_d   = uuid_q;
      last_grant_d = grant_wid;
      uuid_d       = uuid_q + UUID_WIDTH'(1);
    end

    any_pending = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (pending_d[w] != '0) any_pending = 1'b1;
    end
    busy_d = (|active_d) | out_valid_d | any_pending;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q     <= '0;
      last_grant_q <= NW_WIDTH'(NUM_WARPS - 1);
      uuid_q       <= '0;
      out_valid_q  <= 1'b0;
      out_wid_q    <= '0;
      out_pc_q     <= '0;
      out_tmask_q  <= '0;
      out_uuid_q   <= '0;
      busy_q       <= 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_q[w]      <= '0;
        tmask_q[w]   <= '0;
        pending_q[w] <= '0;
      end
    end else begin
      active_q     <= active_d;
      last_grant_q <= last_grant_d;
      uuid_q       <= uuid_d;
      out_valid_q  <= out_valid_d;
      out_wid_q    <= out_wid_d;
      out_pc_q     <= out_pc_d;
      out_tmask_q  <= out_tmask_d;
      out_uuid_q   <= out_uuid_d;
      busy_q       <= busy_d;
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_q[w]      <= pc_d[w];
        tmask_q[w]   <= tmask_d[w];
        pending_q[w] <= pending_d[w];
      end
    end
  end

  assign sched_if.sched_valid = out_valid_q;
  assign sched_if.sched_wid   = out_wid_q;
  assign sched_if.sched_pc    = out_pc_q;
  assign sched_if.sched_tmask = out_tmask_q;
  assign sched_if.sched_uuid  = out_uuid_q;
  assign active_warps         = active_q;
  assign busy                 = busy_q;

`ifndef SYNTHESIS
  // Flag ibuffer pops for a warp that has nothing in flight
  always @(posedge clk) begin
    if (reset_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        assert (!(ibuf_pop[w] && (pending_q[w] == '0)));
      end
    end
  end
`endif

endmodule
`default_nettype wire
